mul_share_ctrl: RTL and testbench

- Two-requester controller that time-shares one iterative mantissa multiplier.
- The multiplier is a start/done unit that must be cleared before each new start; this block sequences it.
- Accepts operand pairs over valid/ready and arbitrates round-robin.
- Sequences the multiplier's clear/start/done protocol and returns each product to its requester over valid/ready.
- Sits between the FP multiply/divide pipelines and the shared multiplier instance.

---
 rtl/mul_share_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mul_share_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl -- lets two requesters share one iterative mantissa multiplier.
//
// Operand pairs come in over valid/ready and are arbitrated round-robin. The
// multiplier's clear/start/done protocol is sequenced for each operation, and
// the product goes back to the requester that issued it over valid/ready.
//
// Optional feature macro: MUL_SHARE_ZERO_BYPASS_EN
//   When defined, an accepted pair with a zero operand skips the multiplier and
//   answers with a product of 0 in the cycle after acceptance.
//
// Ports:
//   clock, reset                  clock; asynchronous active-low reset
//   reqN{Valid,Ready,A,B}         operand request channel, N = 0/1 (W bits each)
//   respN{Valid,Ready,Prod}       product response channel, N = 0/1 (P bits)
//   mulIn1, mulIn2                operands to the shared multiplier
//   mulStart                      one-cycle start pulse
//   mulClear                      clear to multiplier (also high while reset low)
//   mulDone, mulOut               multiplier done level and product
module mul_share_ctrl #(
    parameter int FRAC_WIDTH = 23
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req0Valid,
    output logic                      req0Ready,
    input  logic [FRAC_WIDTH:0]       req0A,
    input  logic [FRAC_WIDTH:0]       req0B,
    output logic                      resp0Valid,
    input  logic                      resp0Ready,
    output logic [2*FRAC_WIDTH+1:0]   resp0Prod,
    input  logic                      req1Valid,
    output logic                      req1Ready,
    input  logic [FRAC_WIDTH:0]       req1A,
    input  logic [FRAC_WIDTH:0]       req1B,
    output logic                      resp1Valid,
    input  logic                      resp1Ready,
    output logic [2*FRAC_WIDTH+1:0]   resp1Prod,
    output logic [FRAC_WIDTH:0]       mulIn1,
    output logic [FRAC_WIDTH:0]       mulIn2,
    output logic                      mulStart,
    output logic                      mulClear,
    input  logic                      mulDone,
    input  logic [2*FRAC_WIDTH+1:0]   mulOut
);
    localparam int W = FRAC_WIDTH + 1;
    localparam int P = 2 * W;

    typedef enum logic [2:0] {IDLE, CLEAR, START, BUSY, RESP} state_t;

    state_t         state, state_nxt;
    logic           last_grant;
    logic           gnt_id;
    logic [W-1:0]   op_a, op_b;
    logic [P-1:0]   result;

    // Round-robin pick: on a tie the requester that did not win last time goes.
    logic           want0, want1, accept;
    logic [W-1:0]   sel_a, sel_b;
    logic           sel_zero;

    assign want0    = req0Valid & (~req1Valid | last_grant);
    assign want1    = req1Valid & (~req0Valid | ~last_grant);
    assign accept   = (state == IDLE) & (want0 | want1);
    assign sel_a    = want1 ? req1A : req0A;
    assign sel_b    = want1 ? req1B : req0B;
    assign sel_zero = (sel_a == '0) | (sel_b == '0);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MUL_SHARE_ZERO_BYPASS_EN
                    state_nxt = sel_zero ? RESP : CLEAR;
`else
                    state_nxt = CLEAR;
`endif
                end
            end
            CLEAR:   state_nxt = START;
            START:   state_nxt = BUSY;
            // mulDone may still be high from the previous operation until the
            // clear takes effect, so it is only looked at here.
            BUSY:    if (mulDone) state_nxt = RESP;
            RESP:    if (gnt_id ? resp1Ready : resp0Ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand / grant / result registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            gnt_id     <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            result     <= '0;
        end else begin
            if (accept) begin
                last_grant <= want1;
                gnt_id     <= want1;
                op_a       <= sel_a;
                op_b       <= sel_b;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
                if (sel_zero) result <= '0;
`endif
            end
            if (state == BUSY && mulDone) result <= mulOut;
        end
    end

    // Outputs. Everything is gated so it reads 0 while reset is held low,
    // except mulClear, which holds the multiplier in its wait state.
    always_comb begin
        req0Ready  = 1'b0;
        req1Ready  = 1'b0;
        resp0Valid = 1'b0;
        resp1Valid = 1'b0;
        resp0Prod  = '0;
        resp1Prod  = '0;
        mulIn1     = '0;
        mulIn2     = '0;
        mulStart   = 1'b0;
        mulClear   = ~reset;
        if (reset) begin
            case (state)
                IDLE: begin
                    req0Ready = want0;
                    req1Ready = want1;
                end
                CLEAR: begin
                    mulClear = 1'b1;
                    mulIn1   = op_a;
                    mulIn2   = op_b;
                end
                START: begin
                    mulStart = 1'b1;
                    mulIn1   = op_a;
                    mulIn2   = op_b;
                end
                BUSY: begin
                    mulIn1 = op_a;
                    mulIn2 = op_b;
                end
                RESP: begin
                    if (gnt_id) begin
                        resp1Valid = 1'b1;
                        resp1Prod  = result;
                    end else begin
                        resp0Valid = 1'b1;
                        resp0Prod  = result;
                    end
                end
                default: ;
            endcase
        end
    end

    // sel_zero only steers the optional bypass path.
    logic unused_ok;
    assign unused_ok = sel_zero;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl (FRAC_WIDTH=23). The bench plays the
// multiplier itself, driving mulDone/mulOut with hand-computed products, and
// checks every control and data output step by step.
module tb_mul_share_ctrl;
    localparam int W = 24;
    localparam int P = 48;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         req0Valid = 1'b0, req1Valid = 1'b0;
    logic         req0Ready, req1Ready;
    logic [W-1:0] req0A = '0, req0B = '0, req1A = '0, req1B = '0;
    logic         resp0Valid, resp1Valid;
    logic         resp0Ready = 1'b0, resp1Ready = 1'b0;
    logic [P-1:0] resp0Prod, resp1Prod;
    logic [W-1:0] mulIn1, mulIn2;
    logic         mulStart, mulClear;
    logic         mulDone = 1'b0;
    logic [P-1:0] mulOut = '0;

    int errors = 0;
    int checks = 0;

    mul_share_ctrl #(.FRAC_WIDTH(23)) dut (
        .clock(clock), .reset(reset),
        .req0Valid(req0Valid), .req0Ready(req0Ready), .req0A(req0A), .req0B(req0B),
        .resp0Valid(resp0Valid), .resp0Ready(resp0Ready), .resp0Prod(resp0Prod),
        .req1Valid(req1Valid), .req1Ready(req1Ready), .req1A(req1A), .req1B(req1B),
        .resp1Valid(resp1Valid), .resp1Ready(resp1Ready), .resp1Prod(resp1Prod),
        .mulIn1(mulIn1), .mulIn2(mulIn2), .mulStart(mulStart), .mulClear(mulClear),
        .mulDone(mulDone), .mulOut(mulOut)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after the request handshake edge (controller in CLEAR).
    // Walks CLEAR/START/BUSY, returns prod, holds the response 'hold' cycles,
    // then completes the response handshake. With 'early', mulDone is left
    // high (with a bogus product) through CLEAR and START.
    task automatic serve(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                         input logic [P-1:0] prod, input bit id, input int hold, input bit early);
        if (early) begin
            mulDone = 1'b1;
            mulOut  = 48'hDEAD_BEEF_0001;
        end
        #1;
        chk({tag, " clear"},     64'(mulClear), 64'd1);
        chk({tag, " clr.start"}, 64'(mulStart), 64'd0);
        chk({tag, " clr.in1"},   64'(mulIn1),   64'(ea));
        chk({tag, " clr.in2"},   64'(mulIn2),   64'(eb));
        chk({tag, " clr.rdy"},   64'({req0Ready, req1Ready}), 64'd0);
        tick();
        chk({tag, " start"},     64'(mulStart), 64'd1);
        chk({tag, " st.clear"},  64'(mulClear), 64'd0);
        chk({tag, " st.in1"},    64'(mulIn1),   64'(ea));
        chk({tag, " st.in2"},    64'(mulIn2),   64'(eb));
        tick();
        mulDone = 1'b0;
        #1;
        chk({tag, " busy.start"}, 64'(mulStart), 64'd0);
        chk({tag, " busy.in1"},   64'(mulIn1),   64'(ea));
        chk({tag, " busy.in2"},   64'(mulIn2),   64'(eb));
        chk({tag, " busy.resp"},  64'({resp0Valid, resp1Valid}), 64'd0);
        tick();
        chk({tag, " busy2.resp"}, 64'({resp0Valid, resp1Valid}), 64'd0);
        chk({tag, " busy2.in1"},  64'(mulIn1), 64'(ea));
        mulDone = 1'b1;
        mulOut  = prod;
        tick();
        // Product must come from the result register, not straight from mulOut.
        mulDone = 1'b0;
        mulOut  = '0;
        for (int c = 0; c <= hold; c++) begin
            #1;
            chk({tag, " rsp.v0"},    64'(resp0Valid), id ? 64'd0 : 64'd1);
            chk({tag, " rsp.v1"},    64'(resp1Valid), id ? 64'd1 : 64'd0);
            chk({tag, " rsp.p0"},    64'(resp0Prod),  id ? 64'd0 : 64'(prod));
            chk({tag, " rsp.p1"},    64'(resp1Prod),  id ? 64'(prod) : 64'd0);
            chk({tag, " rsp.rdy"},   64'({req0Ready, req1Ready}), 64'd0);
            chk({tag, " rsp.start"}, 64'(mulStart), 64'd0);
            if (c < hold) tick();
        end
        if (id) resp1Ready = 1'b1; else resp0Ready = 1'b1;
        tick();
        resp0Ready = 1'b0;
        resp1Ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst.clear", 64'(mulClear), 64'd1);
        chk("rst.outs",  64'({req0Ready, req1Ready, resp0Valid, resp1Valid, mulStart}), 64'd0);
        chk("rst.data",  64'(resp0Prod | resp1Prod | 48'(mulIn1) | 48'(mulIn2)), 64'd0);
        #10 reset = 1'b1;
        #1;
        chk("idle.clear", 64'(mulClear), 64'd0);

        // Single request, 1.0 x 1.0 in 1.23 format
        req0Valid = 1'b1; req0A = 24'h800000; req0B = 24'h800000;
        #1;
        chk("single.rdy0", 64'(req0Ready), 64'd1);
        chk("single.rdy1", 64'(req1Ready), 64'd0);
        tick();
        req0Valid = 1'b0;
        serve("single", 24'h800000, 24'h800000, 48'h400000000000, 1'b0, 0, 1'b0);
        #1;
        chk("single.after.v", 64'(resp0Valid), 64'd0);
        chk("single.after.p", 64'(resp0Prod),  64'd0);

        // Arbitration straight out of reset: req0 first, then req1, then req0 again
        reset = 1'b0; #2; reset = 1'b1;
        req0Valid = 1'b1; req0A = 24'd3; req0B = 24'd5;
        req1Valid = 1'b1; req1A = 24'd7; req1B = 24'd9;
        #1;
        chk("arb.rdy0", 64'(req0Ready), 64'd1);
        chk("arb.rdy1", 64'(req1Ready), 64'd0);
        tick();
        req0Valid = 1'b0;
        serve("arb0", 24'd3, 24'd5, 48'd15, 1'b0, 0, 1'b0);
        #1;
        chk("arb1.rdy1", 64'(req1Ready), 64'd1);
        tick();
        req1Valid = 1'b0;
        serve("arb1", 24'd7, 24'd9, 48'd63, 1'b1, 0, 1'b0);
        req0Valid = 1'b1;
        req1Valid = 1'b1;
        #1;
        chk("alt.rdy0", 64'(req0Ready), 64'd1);
        chk("alt.rdy1", 64'(req1Ready), 64'd0);
        tick();
        req0Valid = 1'b0;
        // Stale mulDone during CLEAR/START must not be taken as the result
        serve("alt.early", 24'd3, 24'd5, 48'd15, 1'b0, 0, 1'b1);

        // Backpressure on resp1 with req0 waiting
        #1;
        chk("bp.rdy1", 64'(req1Ready), 64'd1);
        tick();
        req1Valid = 1'b0;
        req0Valid = 1'b1; req0A = 24'd2; req0B = 24'd2;
        serve("bp", 24'd7, 24'd9, 48'd63, 1'b1, 10, 1'b0);
        req0Valid = 1'b0;

        // Reset in the middle of BUSY
        req0Valid = 1'b1; req0A = 24'd5; req0B = 24'd6;
        #1;
        chk("mid.rdy0", 64'(req0Ready), 64'd1);
        tick();
        req0Valid = 1'b0;
        tick();
        tick();
        chk("mid.busy.in1", 64'(mulIn1), 64'd5);
        req0Valid = 1'b1; req0A = 24'd2; req0B = 24'd2;
        reset = 1'b0;
        #1;
        chk("mid.rst.clear", 64'(mulClear), 64'd1);
        chk("mid.rst.outs",  64'({req0Ready, req1Ready, resp0Valid, resp1Valid, mulStart}), 64'd0);
        chk("mid.rst.in",    64'({mulIn1, mulIn2}), 64'd0);
        tick();
        chk("mid.rst2.clear", 64'(mulClear), 64'd1);
        chk("mid.rst2.outs",  64'({req0Ready, resp0Valid, resp0Prod}), 64'd0);
        reset = 1'b1;
        #1;
        chk("mid.rel.rdy0", 64'(req0Ready), 64'd1);
        chk("mid.rel.resp", 64'(resp0Valid), 64'd0);
        tick();
        req0Valid = 1'b0;
        serve("mid.after", 24'd2, 24'd2, 48'd4, 1'b0, 0, 1'b0);

        // Zero operand
        req0Valid = 1'b1; req0A = 24'd0; req0B = 24'hFFFFFF;
        #1;
        chk("zero.rdy0", 64'(req0Ready), 64'd1);
        tick();
        req0Valid = 1'b0;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
        #1;
        chk("zero.byp.v",     64'(resp0Valid), 64'd1);
        chk("zero.byp.p",     64'(resp0Prod),  64'd0);
        chk("zero.byp.clear", 64'(mulClear),   64'd0);
        chk("zero.byp.start", 64'(mulStart),   64'd0);
        resp0Ready = 1'b1;
        tick();
        resp0Ready = 1'b0;
`else
        serve("zero", 24'd0, 24'hFFFFFF, 48'd0, 1'b0, 0, 1'b0);
`endif
        #1;
        chk("zero.after.v", 64'(resp0Valid), 64'd0);
        chk("zero.after.s", 64'(mulStart),   64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
